// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

    // Bus sequencing states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    // Requester identifiers, also used as the owner encoding.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LS    = 1'b1;

    // Width of the wait-state counter; covers WAIT_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Wait-state down-counter: load at grant, decrement during the access, flag zero.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement; never wrap below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port external memory bus arbiter (fetch port 0, load/store port 1).
// Each access holds CS for WAIT_CYCLES+1 cycles, then pulses the owner's ack for one cycle.
// Optional: define ARB_ROUND_ROBIN_EN to alternate between ports on simultaneous requests;
// otherwise port 1 always wins.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_BUS_WRITE,
    input  logic [DATA_W-1:0] Data_BUS_READ,
    output logic              CS,
    output logic              WR_RD,
    output logic              busy,
    output logic              owner
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              owner_q, owner_d;
    logic              winner;
    logic              grant;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;

    assign grant = (state_q == StIdle) && (req0 || req1);

`ifdef ARB_ROUND_ROBIN_EN
    // Preferred port for a tie; starts at port 1 and flips away from each grantee.
    logic pref_q, pref_d;

    // Arbitration: a lone request always wins, ties go to the preferred port.
    always_comb begin
        winner = req1 ? PORT_LS : PORT_FETCH;
        if (req0 && req1) begin
            winner = pref_q;
        end
    end

    // Pointer update on every grant.
    always_comb begin
        pref_d = pref_q;
        if (grant) begin
            pref_d = ~winner;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            pref_q <= PORT_LS;
        end else begin
            pref_q <= pref_d;
        end
    end
`else
    // Fixed priority: load/store beats fetch so fetch cannot starve it.
    always_comb begin
        winner = req1 ? PORT_LS : PORT_FETCH;
    end
`endif

    arb_wait_counter u_wait_counter (
        .clk_i      (CLK),
        .rst_ni     (Rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // FSM next-state and registered bus outputs.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cs_d     = cs_q;
        wr_d     = wr_q;
        owner_d  = owner_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d  = StAccess;
                    owner_d  = winner;
                    cs_d     = 1'b1;
                    cnt_load = 1'b1;
                    if (winner == PORT_LS) begin
                        addr_d  = addr1;
                        wr_d    = we1;
                        wdata_d = we1 ? wdata1 : '0;
                    end else begin
                        addr_d  = addr0;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            StAccess: begin
                if (cnt_zero) begin
                    state_d = StDone;
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (owner_q == PORT_LS) begin
                        ack1_d = 1'b1;
                        if (!wr_q) begin
                            rdata1_d = Data_BUS_READ;
                        end
                    end else begin
                        ack0_d   = 1'b1;
                        rdata0_d = Data_BUS_READ;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            owner_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            owner_q  <= owner_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign ADDR           = addr_q;
    assign Data_BUS_WRITE = wdata_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign CS             = cs_q;
    assign WR_RD          = wr_q;
    assign owner          = owner_q;
    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign busy           = (state_q != StIdle);

endmodule
